// File: rtl/alu_seq_pkg.sv
// Shared types and instruction-field helpers for the ALU sequencer.
// Imported by the interface, register file and control unit.
package alu_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_e;

    localparam logic [2:0] OP_HALT   = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_SUB    = 3'd2;
    localparam logic [2:0] OP_AND    = 3'd3;
    localparam logic [2:0] OP_NOT    = 3'd4;
    localparam logic [2:0] OP_OR     = 3'd5;
    localparam logic [2:0] OP_EQ     = 3'd6;
    localparam logic [2:0] OP_BRANCH = 3'd7;

    localparam int  CLASS_BIT   = 15;
    localparam logic CLASS_LOADI = 1'b1;
    localparam int  LI_RD_LO    = 13;
    localparam int  OP_LO       = 12;
    localparam int  RD_LO       = 10;
    localparam int  RS_LO       = 8;
    localparam int  RT_LO       = 6;
    localparam int  TGT_LO      = 0;
    localparam int  IMM_LO      = 0;

    function automatic logic f_is_loadi(logic [INSTR_W-1:0] ir);
        return ir[CLASS_BIT] == CLASS_LOADI;
    endfunction

    function automatic logic [2:0] f_op(logic [INSTR_W-1:0] ir);
        return ir[OP_LO+:3];
    endfunction

    function automatic logic [1:0] f_rd(logic [INSTR_W-1:0] ir);
        return ir[RD_LO+:2];
    endfunction

    function automatic logic [1:0] f_rs(logic [INSTR_W-1:0] ir);
        return ir[RS_LO+:2];
    endfunction

    function automatic logic [1:0] f_rt(logic [INSTR_W-1:0] ir);
        return ir[RT_LO+:2];
    endfunction

    function automatic logic [ADDR_W-1:0] f_tgt(logic [INSTR_W-1:0] ir);
        return ir[TGT_LO+:ADDR_W];
    endfunction

    function automatic logic [1:0] f_li_rd(logic [INSTR_W-1:0] ir);
        return ir[LI_RD_LO+:2];
    endfunction

    function automatic logic [DATA_W-1:0] f_imm(logic [INSTR_W-1:0] ir);
        return ir[IMM_LO+:DATA_W];
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction-memory handshake and ALU bus of the sequencer.
// master = sequencer side, slave = memory/ALU side.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic               IMEM_REQ;
    logic [ADDR_W-1:0]  IMEM_ADDR;
    logic               IMEM_VALID;
    logic [INSTR_W-1:0] IMEM_DATA;
    logic [DATA_W-1:0]  ALU_A;
    logic [DATA_W-1:0]  ALU_B;
    logic [ADDR_W-1:0]  ALU_ADDR;
    logic [2:0]         ALU_OP;
    logic [DATA_W-1:0]  ALU_RESULT;
    logic               ALU_CO;
    logic               ALU_EQ;
    logic               ALU_BRANCH;

    modport master (
        output IMEM_REQ, IMEM_ADDR,
        input  IMEM_VALID, IMEM_DATA,
        output ALU_A, ALU_B, ALU_ADDR, ALU_OP,
        input  ALU_RESULT, ALU_CO, ALU_EQ, ALU_BRANCH
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR,
        output IMEM_VALID, IMEM_DATA,
        input  ALU_A, ALU_B, ALU_ADDR, ALU_OP,
        output ALU_RESULT, ALU_CO, ALU_EQ, ALU_BRANCH
    );

endinterface

// File: rtl/reg_file_4x8.sv
// 4x8 register file: two async operand reads, one debug read,
// one synchronous write, async clear to zero.
module reg_file_4x8
    import alu_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [1:0]        wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [1:0]        ra_a_i,
    output logic [DATA_W-1:0] rd_a_o,
    input  logic [1:0]        ra_b_i,
    output logic [DATA_W-1:0] rd_b_o,
    input  logic [1:0]        ra_dbg_i,
    output logic [DATA_W-1:0] rd_dbg_o
);

    logic [DATA_W-1:0] regs_q [4];

    // Storage: cleared on reset, written on a WB strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o   = regs_q[ra_a_i];
    assign rd_b_o   = regs_q[ra_b_i];
    assign rd_dbg_o = regs_q[ra_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit: fetch, decode, drive ALU, write back.
// Owns the PC, branch redirection and the sticky carry flag.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    alu_sequencer_if.master   bus,
    output logic              CARRY,
    output logic              BUSY,
    output logic              HALTED,
    output logic [ADDR_W-1:0] PC,
    input  logic [1:0]        REG_RD_SEL,
    output logic [DATA_W-1:0] REG_RD_DATA
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               carry_q, carry_d;

    logic               we;
    logic [1:0]         wa;
    logic [DATA_W-1:0]  wd;
    logic [DATA_W-1:0]  rd_a, rd_b;
    logic               is_li;
    logic [2:0]         op;

    assign is_li = f_is_loadi(ir_q);
    assign op    = f_op(ir_q);

    reg_file_4x8 u_rf (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .we_i     (we),
        .wa_i     (wa),
        .wd_i     (wd),
        .ra_a_i   (f_rs(ir_q)),
        .rd_a_o   (rd_a),
        .ra_b_i   (f_rt(ir_q)),
        .rd_b_o   (rd_b),
        .ra_dbg_i (REG_RD_SEL),
        .rd_dbg_o (REG_RD_DATA)
    );

    // State, PC, instruction and carry registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

    // Next-state, fetch request, ALU opcode and write-back strobes.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        carry_d      = carry_q;
        we           = 1'b0;
        wa           = '0;
        wd           = '0;
        bus.IMEM_REQ = 1'b0;
        bus.ALU_OP   = OP_HALT;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (START) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    carry_d = 1'b0;
                end
            end
            S_FETCH: begin
                bus.IMEM_REQ = 1'b1;
                if (bus.IMEM_VALID) begin
                    ir_d    = bus.IMEM_DATA;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_li:           state_d = S_WB;
                    (op == OP_HALT): state_d = S_HALTED;
                    default:         state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                bus.ALU_OP = op;
                state_d    = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
                pc_d    = pc_q + 1'b1;
                if (is_li) begin
                    we = 1'b1;
                    wa = f_li_rd(ir_q);
                    wd = f_imm(ir_q);
                end else if (op == OP_BRANCH) begin
                    if (bus.ALU_BRANCH) pc_d = f_tgt(ir_q);
                end else if (op != OP_EQ) begin
                    we = 1'b1;
                    wa = f_rd(ir_q);
                    wd = bus.ALU_RESULT;
                    if (op == OP_ADD || op == OP_SUB)
                        carry_d = carry_q | bus.ALU_CO;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.IMEM_ADDR = pc_q;
    assign bus.ALU_A     = rd_a;
    assign bus.ALU_B     = rd_b;
    assign bus.ALU_ADDR  = f_tgt(ir_q);

    assign CARRY  = carry_q;
    assign PC     = pc_q;
    assign HALTED = (state_q == S_HALTED);
    assign BUSY   = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit that fetches 16-bit instructions from a 64-word instruction memory, reads operands from a 4x8 register file, drives the clocked 8-bit ALU (op/A/B/branch_addr), and writes back results. It sits between instruction memory and the ALU, forming the processor's control path. It owns the PC and branch redirection and holds a sticky carry flag.

Parameters:
DATA_W, 8, ALU operand/result width
ADDR_W, 6, PC / branch target width (64-word program space)
INSTR_W, 16, instruction width

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  single-cycle pulse; begins execution at PC=0 when IDLE or HALTED
IMEM_REQ  out  1  fetch request, held until IMEM_VALID
IMEM_ADDR  out  6  fetch address (= PC)
IMEM_VALID  in  1  fetch data valid; sampled only while IMEM_REQ=1
IMEM_DATA  in  16  instruction word
ALU_A  out  8  operand A (reg[rs])
ALU_B  out  8  operand B (reg[rt])
ALU_ADDR  out  6  branch target to ALU
ALU_OP  out  3  ALU opcode; 0 (NOP) outside EXEC
ALU_RESULT  in  8  ALU result, valid one cycle after op presented
ALU_CO  in  1  ALU carry/borrow out
ALU_EQ  in  1  ALU equality flag
ALU_BRANCH  in  1  ALU branch-taken flag
CARRY  out  1  sticky carry, set by ADD/SUB with ALU_CO=1, cleared by START
BUSY  out  1  1 in any state except IDLE/HALTED
HALTED  out  1  1 in HALTED state
PC  out  6  current program counter
REG_RD_SEL  in  2  debug register read select
REG_RD_DATA  out  8  reg[REG_RD_SEL], combinational

Behaviour:
- Instruction format: bit15=class. Class 1 LOADI: [14:13] rd, [7:0] imm8. Class 0 ALU: [14:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [5:0] target.
- ALU-class ops: 0 HALT, 1 ADD, 2 SUB, 3 AND, 4 NOT(A), 5 OR, 6 EQ, 7 BRANCH.
- Reset (async, RST_N=0): state IDLE, PC=0, regs 0, CARRY=0, IMEM_REQ=0, ALU_OP=0, ALU_A/B/ADDR=0, BUSY=0, HALTED=0.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE/HALTED: START -> FETCH, PC<=0, CARRY<=0. START in any other state ignored.
- FETCH: IMEM_REQ=1, IMEM_ADDR=PC; IMEM_ADDR stable until IMEM_VALID. On IMEM_VALID latch IR -> DECODE. Unbounded wait permitted.
- DECODE: LOADI -> WB; op 0 -> HALTED (PC unchanged); else -> EXEC.
- EXEC (1 cycle): drive ALU_OP=op, ALU_A=reg[rs], ALU_B=reg[rt], ALU_ADDR=target -> WB.
- WB (ALU_OP back to 0; ALU outputs sampled this cycle):
  - ops 1-5: reg[rd]<=ALU_RESULT; ops 1/2: CARRY |= ALU_CO.
  - op 6: no register write.
  - op 7: PC<=target if ALU_BRANCH else PC+1.
  - LOADI: reg[rd]<=imm8.
  - non-branch: PC<=PC+1. -> FETCH.
- PC arithmetic mod 64: 63+1 wraps to 0.
- Latency with zero-wait memory: ALU instr 4 cycles, LOADI 3 cycles, HALT 2 cycles.
- Register writes occur only in WB; debug read reflects the write in the cycle after WB.
- Reset mid-instruction: immediate return to reset values; an outstanding fetch is abandoned (IMEM_REQ drops asynchronously).
- IMEM_VALID outside FETCH: ignored.

Decomposition:
- Package alu_seq_pkg: state enum, ALU opcode constants (OP_HALT..OP_BRANCH), instruction field bit positions, CLASS_LOADI.
- Sub-module reg_file_4x8: 2 async read ports + debug read port, 1 sync write port, async active-low reset to 0.

Test Plan:
1. LOADI r1=0x12; LOADI r2=0x03; ADD r3=r1+r2; HALT; START -> r3=0x15, CARRY=0, HALTED=1 after 3+3+4+2 = 12 cycles post-START, PC=3.
2. LOADI r1=0xFF; LOADI r2=0xFF; ADD r3; HALT -> r3=0xFE, CARRY=1. Then SUB 0x07-0x07 in a fresh program after START -> result 0x00, CARRY cleared by START.
3. r1=r2=0x15; EQ r1,r2; BRANCH target=0x24 -> next IMEM_ADDR=0x24. Repeat with r1=0x17 -> next IMEM_ADDR=branch PC+1.
4. Hold IMEM_VALID low 3 cycles during FETCH -> IMEM_REQ=1 and IMEM_ADDR unchanged throughout, no register/PC change, resumes on VALID.
5. Program with no HALT at address 63 -> PC wraps to 0, IMEM_ADDR=0. A START pulse while BUSY -> no effect.
6. Assert RST_N=0 during EXEC -> BUSY=0, ALU_OP=0, IMEM_REQ=0, PC=0, all regs read 0 via REG_RD_DATA.
